// File: rtl/fir_pkg.sv
// Shared sizes and state encoding for the FIR tap loader.
package fir_pkg;
    localparam int NTAPS = 7;
    localparam int CW    = 8;
    localparam int XW    = 8;
    localparam int TW    = $clog2(NTAPS);

    localparam logic [TW-1:0] LAST_IDX = TW'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, FLUSH} state_t;
endpackage

// File: rtl/fir_shadow_bank.sv
// Shadow coefficient buffer plus the active set seen by the FIR.
// Shadow fills one tap per write; commit copies the whole set in one edge.
module fir_shadow_bank
    import fir_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [TW-1:0]            wr_idx_i,
    input  logic [CW-1:0]            wr_data_i,
    input  logic                     clr_i,
    input  logic                     commit_i,
    output logic [NTAPS-1:0][CW-1:0] active_o
);
    logic [NTAPS-1:0][CW-1:0] shadow_q;
    logic [NTAPS-1:0][CW-1:0] active_q;

    // Discard wins over a write landing in the same cycle as a length error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
        end else if (clr_i) begin
            shadow_q <= '0;
        end else begin
            for (int i = 0; i < NTAPS; i++)
                if (wr_en_i && wr_idx_i == TW'(i)) shadow_q[i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         active_q <= '0;
        else if (commit_i) active_q <= shadow_q;
    end

    assign active_o = active_q;
endmodule

// File: rtl/fir_tap_loader.sv
// Sample / coefficient front end for the 7-tap transposed FIR.
// Define FIR_FLUSH_EN to zero-stuff Xin for NTAPS cycles after each commit.
module fir_tap_loader
    import fir_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Cfg_Valid,
    output logic          Cfg_Ready,
    input  logic [CW-1:0] Cfg_Data,
    input  logic          Cfg_Last,
    input  logic          Smp_Valid,
    output logic          Smp_Ready,
    input  logic [XW-1:0] Smp_Data,
    output logic [XW-1:0] Xin,
    output logic [CW-1:0] B0,
    output logic [CW-1:0] B1,
    output logic [CW-1:0] B2,
    output logic [CW-1:0] B3,
    output logic [CW-1:0] B4,
    output logic [CW-1:0] B5,
    output logic [CW-1:0] B6,
    output logic          Busy,
    output logic          Err
);
    state_t                   state_q, state_d;
    logic [TW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [XW-1:0]            xin_q;
    logic                     wr_en, clr, commit;
    logic [NTAPS-1:0][CW-1:0] active;
`ifdef FIR_FLUSH_EN
    logic [TW-1:0]            fcnt_q, fcnt_d;
`endif

    assign Cfg_Ready = (state_q == IDLE) || (state_q == LOAD);
`ifdef FIR_FLUSH_EN
    assign Smp_Ready = (state_q != COMMIT) && (state_q != FLUSH);
    assign Busy      = (state_q == COMMIT) || (state_q == FLUSH);
`else
    assign Smp_Ready = 1'b1;
    assign Busy      = (state_q == COMMIT);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        clr     = 1'b0;
        commit  = 1'b0;
`ifdef FIR_FLUSH_EN
        fcnt_d  = fcnt_q;
`endif
        case (state_q)
            IDLE, LOAD: begin
                if (Cfg_Valid) begin
                    wr_en = 1'b1;
                    if (Cfg_Last && cnt_q == LAST_IDX) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else if (Cfg_Last || cnt_q == LAST_IDX) begin
                        // Wrong set length: drop the partial set, keep active taps.
                        err_d   = 1'b1;
                        clr     = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + TW'(1);
                        state_d = LOAD;
                    end
                end
            end
            COMMIT: begin
                commit = 1'b1;
`ifdef FIR_FLUSH_EN
                fcnt_d  = LAST_IDX;
                state_d = FLUSH;
`else
                state_d = IDLE;
`endif
            end
            FLUSH: begin
`ifdef FIR_FLUSH_EN
                if (fcnt_q == '0) state_d = IDLE;
                else              fcnt_d  = fcnt_q - TW'(1);
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            xin_q   <= '0;
`ifdef FIR_FLUSH_EN
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Cycles without an accepted sample feed zeros into the FIR.
            xin_q   <= (Smp_Valid && Smp_Ready) ? Smp_Data : '0;
`ifdef FIR_FLUSH_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    fir_shadow_bank u_bank (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .wr_en_i   (wr_en),
        .wr_idx_i  (cnt_q),
        .wr_data_i (Cfg_Data),
        .clr_i     (clr),
        .commit_i  (commit),
        .active_o  (active)
    );

    assign Xin = xin_q;
    assign Err = err_q;
    assign B0  = active[0];
    assign B1  = active[1];
    assign B2  = active[2];
    assign B3  = active[3];
    assign B4  = active[4];
    assign B5  = active[5];
    assign B6  = active[6];
endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader; follows FIR_FLUSH_EN like the RTL.
module tb_fir_tap_loader;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Cfg_Valid = 1'b0, Cfg_Last = 1'b0, Smp_Valid = 1'b0;
    logic [7:0] Cfg_Data = '0, Smp_Data = '0;
    logic       Cfg_Ready, Smp_Ready, Busy, Err;
    logic [7:0] Xin, B0, B1, B2, B3, B4, B5, B6;
    logic [55:0] bcat, bexp;
    int checks = 0, errors = 0;

    assign bcat = {B6, B5, B4, B3, B2, B1, B0};

    always #5 Clk = ~Clk;

    fir_tap_loader dut (
        .Clk(Clk), .Rst(Rst),
        .Cfg_Valid(Cfg_Valid), .Cfg_Ready(Cfg_Ready), .Cfg_Data(Cfg_Data), .Cfg_Last(Cfg_Last),
        .Smp_Valid(Smp_Valid), .Smp_Ready(Smp_Ready), .Smp_Data(Smp_Data),
        .Xin(Xin), .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6),
        .Busy(Busy), .Err(Err)
    );

    task tick;
        @(posedge Clk);
        #1;
    endtask

    task set_bexp(input logic [7:0] base);
        for (int i = 0; i < 7; i++) bexp[i*8 +: 8] = base + 8'(i);
    endtask

    task drive_beats(input int n, input int last_at, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            Cfg_Valid = 1'b1;
            Cfg_Data  = base + 8'(i);
            Cfg_Last  = (i == last_at);
            tick();
        end
        Cfg_Valid = 1'b0;
        Cfg_Last  = 1'b0;
    endtask

    task test_reset;
        Rst = 1'b1;
        tick(); tick();
        checks++; if (Xin !== 8'h00) begin errors++; $display("FAIL reset_xin: got %h exp 00", Xin); end
        checks++; if (bcat !== 56'h0) begin errors++; $display("FAIL reset_b: got %h exp 0", bcat); end
        checks++; if ({Busy, Err} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b exp 00", {Busy, Err}); end
        checks++; if ({Cfg_Ready, Smp_Ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b exp 11", {Cfg_Ready, Smp_Ready}); end
        Rst = 1'b0;
        tick();
    endtask

    task test_samples;
        Smp_Valid = 1'b1; Smp_Data = 8'h18;
        tick();
        checks++; if (Xin !== 8'h18) begin errors++; $display("FAIL smp_first: got %h exp 18", Xin); end
        Smp_Data = 8'h08;
        tick();
        checks++; if (Xin !== 8'h08) begin errors++; $display("FAIL smp_second: got %h exp 08", Xin); end
        Smp_Valid = 1'b0; Smp_Data = 8'hFF;
        tick();
        checks++; if (Xin !== 8'h00) begin errors++; $display("FAIL smp_zero_stuff: got %h exp 00", Xin); end
        checks++; if (bcat !== 56'h0) begin errors++; $display("FAIL smp_b_zero: got %h exp 0", bcat); end
    endtask

    // Full set with a sample every cycle alongside the config beats.
    task test_load_commit(input logic [7:0] base);
        logic [55:0] bold;
        bold = bcat;
        for (int i = 0; i < 7; i++) begin
            Cfg_Valid = 1'b1; Cfg_Data = base + 8'(i); Cfg_Last = (i == 6);
            Smp_Valid = 1'b1; Smp_Data = base + 8'h80 + 8'(i);
            checks++; if ({Cfg_Ready, Smp_Ready} !== 2'b11) begin errors++; $display("FAIL load_ready beat %0d: got %b exp 11", i, {Cfg_Ready, Smp_Ready}); end
            tick();
            checks++; if (Xin !== base + 8'h80 + 8'(i)) begin errors++; $display("FAIL load_xin beat %0d: got %h exp %h", i, Xin, base + 8'h80 + 8'(i)); end
        end
        Cfg_Valid = 1'b0; Cfg_Last = 1'b0;
        Smp_Data = 8'hAA;
        checks++; if (Busy !== 1'b1 || Cfg_Ready !== 1'b0) begin errors++; $display("FAIL commit_state: got busy=%b cfg_rdy=%b exp 1 0", Busy, Cfg_Ready); end
        checks++; if (bcat !== bold) begin errors++; $display("FAIL commit_early: got %h exp %h", bcat, bold); end
        tick();
        set_bexp(base);
        checks++; if (bcat !== bexp) begin errors++; $display("FAIL commit_taps: got %h exp %h", bcat, bexp); end
        checks++; if (Err !== 1'b0) begin errors++; $display("FAIL commit_err: got %b exp 0", Err); end
`ifdef FIR_FLUSH_EN
        Smp_Data = 8'h55;
        for (int k = 0; k < 7; k++) begin
            checks++; if ({Busy, Smp_Ready, Cfg_Ready} !== 3'b100 || Xin !== 8'h00) begin
                errors++; $display("FAIL flush cyc %0d: got busy/srdy/crdy=%b xin=%h exp 100 00", k, {Busy, Smp_Ready, Cfg_Ready}, Xin);
            end
            tick();
        end
        checks++; if ({Busy, Smp_Ready} !== 2'b01 || Xin !== 8'h00) begin errors++; $display("FAIL flush_exit: got busy/srdy=%b xin=%h exp 01 00", {Busy, Smp_Ready}, Xin); end
        tick();
        checks++; if (Xin !== 8'h55) begin errors++; $display("FAIL post_flush_smp: got %h exp 55", Xin); end
`else
        checks++; if ({Busy, Smp_Ready} !== 2'b01 || Xin !== 8'hAA) begin errors++; $display("FAIL post_commit: got busy/srdy=%b xin=%h exp 01 aa", {Busy, Smp_Ready}, Xin); end
`endif
        Smp_Valid = 1'b0;
        tick();
    endtask

    task test_short_err;
        set_bexp(8'h01);
        drive_beats(3, 2, 8'h10);
        checks++; if (Err !== 1'b1) begin errors++; $display("FAIL short_err_pulse: got %b exp 1", Err); end
        checks++; if (bcat !== bexp) begin errors++; $display("FAIL short_err_taps: got %h exp %h", bcat, bexp); end
        checks++; if ({Busy, Cfg_Ready} !== 2'b01) begin errors++; $display("FAIL short_err_state: got %b exp 01", {Busy, Cfg_Ready}); end
        tick();
        checks++; if (Err !== 1'b0) begin errors++; $display("FAIL short_err_width: got %b exp 0", Err); end
        test_load_commit(8'h21);
    endtask

    task test_nolast_err;
        set_bexp(8'h21);
        drive_beats(7, -1, 8'h70);
        checks++; if (Err !== 1'b1) begin errors++; $display("FAIL nolast_err_pulse: got %b exp 1", Err); end
        checks++; if ({Busy, Cfg_Ready, Smp_Ready} !== 3'b011) begin errors++; $display("FAIL nolast_idle: got %b exp 011", {Busy, Cfg_Ready, Smp_Ready}); end
        tick();
        checks++; if (Err !== 1'b0 || bcat !== bexp) begin errors++; $display("FAIL nolast_after: got err=%b b=%h exp 0 %h", Err, bcat, bexp); end
    endtask

    task test_reset_mid;
        Smp_Valid = 1'b1; Smp_Data = 8'h3C;
        drive_beats(4, -1, 8'h31);
        Smp_Valid = 1'b0;
        Rst = 1'b1;
        #1;
        checks++; if (bcat !== 56'h0 || Xin !== 8'h00) begin errors++; $display("FAIL rst_mid_out: got b=%h xin=%h exp 0 00", bcat, Xin); end
        checks++; if ({Busy, Err, Cfg_Ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_ctl: got %b exp 001", {Busy, Err, Cfg_Ready}); end
        tick();
        Rst = 1'b0;
        tick();
        test_load_commit(8'h41);
    endtask

    task test_back_to_back;
        // Second set straight after the first, samples running throughout.
        test_load_commit(8'h01);
        test_load_commit(8'hA0);
    endtask

    initial begin
        test_reset();
        test_samples();
        test_load_commit(8'h01);
        test_short_err();
        test_nolast_err();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
